// File: rtl/cpu_reg_pkg.sv
// Shared register-bank definitions for the writeback scheduler and its arbiter.
// Build option REG_WB_RR_EN (see wb_arb2) selects round-robin instead of fixed priority.
package cpu_reg_pkg;

    localparam int unsigned NREG       = 8;
    localparam int unsigned REG_ADDR_W = 3;
    localparam int unsigned DATA_W     = 16;

    typedef enum logic {
        REQ_ALU  = 1'b0,
        REQ_LOAD = 1'b1
    } req_id_e;

    function automatic logic [NREG-1:0] reg_onehot(input logic [REG_ADDR_W-1:0] addr);
        return NREG'(1) << addr;
    endfunction

endpackage

// File: rtl/wb_arb2.sv
// Two-requester arbiter for the bank write port; request/grant bits indexed by req_id_e.
// REG_WB_RR_EN defined: round-robin on a last-grant pointer; undefined: load beats ALU.
module wb_arb2
    import cpu_reg_pkg::*;
(
`ifdef REG_WB_RR_EN
    input  logic       clk_i,
    input  logic       rst_i,
`endif
    input  logic [1:0] req_i,
    output logic [1:0] gnt_o
);

`ifdef REG_WB_RR_EN
    req_id_e lg_q, lg_d;

    always_comb begin
        gnt_o = 2'b00;
        case (req_i)
            2'b01:   gnt_o = 2'b01;
            2'b10:   gnt_o = 2'b10;
            // On contention the requester that did not win last time goes first.
            2'b11:   gnt_o = (lg_q == REQ_ALU) ? 2'b10 : 2'b01;
            default: gnt_o = 2'b00;
        endcase
        lg_d = lg_q;
        if (gnt_o[REQ_LOAD]) begin
            lg_d = REQ_LOAD;
        end else if (gnt_o[REQ_ALU]) begin
            lg_d = REQ_ALU;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            lg_q <= REQ_ALU;
        end else begin
            lg_q <= lg_d;
        end
    end
`else
    assign gnt_o[REQ_LOAD] = req_i[REQ_LOAD];
    assign gnt_o[REQ_ALU]  = req_i[REQ_ALU] & ~req_i[REQ_LOAD];
`endif

endmodule

// File: rtl/reg_wb_scheduler.sv
// Register-bank write-port scheduler: arbitrates ALU/load writes, registers the winner onto
// the bank port and keeps a busy scoreboard. REG_WB_RR_EN selects round-robin arbitration.
module reg_wb_scheduler #(
    parameter int unsigned DATA_W = cpu_reg_pkg::DATA_W
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic                                a_valid_i,
    input  logic [cpu_reg_pkg::REG_ADDR_W-1:0]  a_addr_i,
    input  logic [DATA_W-1:0]                   a_data_i,
    output logic                                a_ready_o,
    input  logic                                b_valid_i,
    input  logic [cpu_reg_pkg::REG_ADDR_W-1:0]  b_addr_i,
    input  logic [DATA_W-1:0]                   b_data_i,
    output logic                                b_ready_o,
    output logic                                wr_en_o,
    output logic [cpu_reg_pkg::REG_ADDR_W-1:0]  wr_addr_o,
    output logic [DATA_W-1:0]                   wr_data_o,
    input  logic                                iss_valid_i,
    input  logic [cpu_reg_pkg::REG_ADDR_W-1:0]  iss_addr_i,
    input  logic                                flush_i,
    output logic [cpu_reg_pkg::NREG-1:0]        busy_o
);
    import cpu_reg_pkg::*;

    logic [1:0]            req, gnt;
    logic                  wr_en_q, wr_en_d;
    logic [REG_ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0]     wr_data_q, wr_data_d;
    logic [NREG-1:0]       busy_q, busy_d;

    // Flush masks requests so nothing is accepted and the arbiter pointer stays put.
    assign req[REQ_ALU]  = a_valid_i & ~flush_i;
    assign req[REQ_LOAD] = b_valid_i & ~flush_i;

    wb_arb2 u_arb (
`ifdef REG_WB_RR_EN
        .clk_i (clk_i),
        .rst_i (rst_i),
`endif
        .req_i (req),
        .gnt_o (gnt)
    );

    assign a_ready_o = gnt[REQ_ALU];
    assign b_ready_o = gnt[REQ_LOAD];

    always_comb begin
        wr_en_d   = |gnt;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        if (gnt[REQ_LOAD]) begin
            wr_addr_d = b_addr_i;
            wr_data_d = b_data_i;
        end else if (gnt[REQ_ALU]) begin
            wr_addr_d = a_addr_i;
            wr_data_d = a_data_i;
        end

        // Clear on the committed write first so a same-cycle allocation wins.
        busy_d = busy_q;
        if (wr_en_q) begin
            busy_d = busy_d & ~reg_onehot(wr_addr_q);
        end
        if (iss_valid_i) begin
            busy_d = busy_d | reg_onehot(iss_addr_i);
        end
        if (flush_i) begin
            busy_d = '0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            busy_q    <= '0;
        end else begin
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            busy_q    <= busy_d;
        end
    end

    assign wr_en_o   = wr_en_q;
    assign wr_addr_o = wr_addr_q;
    assign wr_data_o = wr_data_q;
    assign busy_o    = busy_q;

endmodule
